dft_ddr_capture_sel_ctrl: RTL and testbench

- Control-side counterpart of the DDR ATPG one-hot clock gate. The gate decodes a 2-bit capture-clock select and gates DfiClk, DfiCtlClk or APBClk. This block drives that select.
- It loads the select code and the capture timing through a serial test-data-register (TDR) chain from the TAP.
- On a tester trigger it sequences the capture window. It drives ddr_clk_sel[1:0], which goes to the one-hot decoder, and capture_en, which is ORed into the gate enables.
- It sits in the always-on DFT domain next to the DDR one-hot gate.

---
 rtl/dft_ddr_capture_sel_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dft_ddr_capture_sel_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_ddr_capture_sel_ctrl.sv
// dft_ddr_capture_sel_ctrl
// Drives the 2-bit capture-clock select and the capture enable for the DDR
// ATPG one-hot clock gate. The select code and the capture timing are loaded
// through a serial TDR chain. A synchronized tester trigger starts a
// capture window: a launch delay, then N enable cycles, then a done pulse.
//
// Optional build macro: DFT_CAPTURE_PARITY_EN
//   When defined, the chain grows by one even-parity MSB. An update whose
//   parity check fails is rejected and flags upd_err_o.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a trigger; shadow register may be updated
// DELAY  | launch delay, dcnt counts down from the dly field
// PULSE  | capture_en high, pcnt counts down from the pulse count
// DONE   | one-cycle capture_done, then back to IDLE
module dft_ddr_capture_sel_ctrl #(
   parameter int CNT_W       = 3,
   parameter int DLY_W       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       scan_mode_i,
   input  logic       tdr_si_i,
   input  logic       tdr_shift_en_i,
   input  logic       tdr_update_i,
   output logic       tdr_so_o,
   input  logic       capture_trig_i,
   output logic [1:0] ddr_clk_sel_o,
   output logic       capture_en_o,
   output logic       capture_busy_o,
   output logic       capture_done_o,
   output logic       upd_err_o
);

   // Field portion of the chain: sel, cnt, dly (LSB first)
   localparam int FW = 2 + CNT_W + DLY_W;
`ifdef DFT_CAPTURE_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int SW  = FW + PW;
   localparam int PCW = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SW-1:0]          sr_q, sr_d;
   logic [FW-1:0]          shd_q, shd_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev_q;
   logic                   trig_det_q;
   logic [DLY_W-1:0]       dcnt_q, dcnt_d;
   logic [PCW-1:0]         pcnt_q, pcnt_d;
   logic [1:0]             sel_q;
   logic                   en_q, busy_q, done_q, err_q, err_d;

   logic [1:0]             sh_sel;
   logic [CNT_W-1:0]       sh_cnt;
   logic [DLY_W-1:0]       sh_dly;
   logic [PCW-1:0]         pcnt_load;
   logic                   sync_out;
   logic                   par_ok;
   logic                   upd_req;
   logic                   upd_acc;

   assign sh_sel   = shd_q[1:0];
   assign sh_cnt   = shd_q[2 +: CNT_W];
   assign sh_dly   = shd_q[2 + CNT_W +: DLY_W];
   assign sync_out = sync_q[SYNC_STAGES-1];

   // A zero pulse-count field encodes the full 2^CNT_W pulses
   assign pcnt_load = (sh_cnt == '0) ? PCW'(1 << CNT_W) : {1'b0, sh_cnt};

`ifdef DFT_CAPTURE_PARITY_EN
   // Even parity across the whole chain, parity bit included
   assign par_ok = ~(^sr_q);
`else
   assign par_ok = 1'b1;
`endif

   // Shift wins over a simultaneous update; that case is not an error
   assign upd_req = tdr_update_i & ~tdr_shift_en_i;
   assign upd_acc = upd_req & (state_q == ST_IDLE) & par_ok;

   // TDR shift register, shadow register and sticky update error
   always_comb begin
      sr_d  = sr_q;
      shd_d = shd_q;
      err_d = err_q;
      if (tdr_shift_en_i) begin
         sr_d = {tdr_si_i, sr_q[SW-1:1]};
      end
      if (upd_acc) begin
         shd_d = sr_q[FW-1:0];
      end
      if (upd_req && ((state_q != ST_IDLE) || !par_ok)) begin
         err_d = 1'b1;
      end
   end

   // Chain and configuration registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sr_q  <= '0;
         shd_q <= '0;
         err_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         shd_q <= shd_d;
         err_q <= err_d;
      end
   end

   // Trigger synchronizer with registered rising-edge detect
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
         trig_det_q  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], capture_trig_i};
         sync_prev_q <= sync_out;
         trig_det_q  <= sync_out & ~sync_prev_q;
      end
   end

   // Next-state logic; leaving scan mode aborts the window from any state
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      pcnt_d  = pcnt_q;
      if (!scan_mode_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trig_det_q && (sh_sel != 2'b00)) begin
                  state_d = ST_DELAY;
                  dcnt_d  = sh_dly;
               end
            end
            ST_DELAY: begin
               if (dcnt_q == '0) begin
                  state_d = ST_PULSE;
                  pcnt_d  = pcnt_load;
               end else begin
                  dcnt_d = dcnt_q - DLY_W'(1);
               end
            end
            ST_PULSE: begin
               if (pcnt_q == PCW'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  pcnt_d = pcnt_q - PCW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         dcnt_q  <= '0;
         pcnt_q  <= '0;
         sel_q   <= 2'b00;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pcnt_q  <= pcnt_d;
         sel_q   <= sh_sel;
         en_q    <= (state_d == ST_PULSE);
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign tdr_so_o       = sr_q[0];
   assign ddr_clk_sel_o  = sel_q;
   assign capture_en_o   = en_q;
   assign capture_busy_o = busy_q;
   assign capture_done_o = done_q;
   assign upd_err_o      = err_q;

endmodule

// File: tb/tb_dft_ddr_capture_sel_ctrl.sv
// Directed bench for dft_ddr_capture_sel_ctrl (default parameters).
module tb_dft_ddr_capture_sel_ctrl;

   localparam int FW = 8;
`ifdef DFT_CAPTURE_PARITY_EN
   localparam int SW = FW + 1;
`else
   localparam int SW = FW;
`endif

   logic       clk          = 1'b0;
   logic       rstn         = 1'b0;
   logic       scan_mode    = 1'b0;
   logic       tdr_si       = 1'b0;
   logic       tdr_shift_en = 1'b0;
   logic       tdr_update   = 1'b0;
   logic       capture_trig = 1'b0;
   logic       tdr_so;
   logic [1:0] ddr_clk_sel;
   logic       capture_en;
   logic       capture_busy;
   logic       capture_done;
   logic       upd_err;

   int errors = 0;
   int checks = 0;

   dft_ddr_capture_sel_ctrl #(
      .CNT_W(3), .DLY_W(3), .SYNC_STAGES(2)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .scan_mode_i    (scan_mode),
      .tdr_si_i       (tdr_si),
      .tdr_shift_en_i (tdr_shift_en),
      .tdr_update_i   (tdr_update),
      .tdr_so_o       (tdr_so),
      .capture_trig_i (capture_trig),
      .ddr_clk_sel_o  (ddr_clk_sel),
      .capture_en_o   (capture_en),
      .capture_busy_o (capture_busy),
      .capture_done_o (capture_done),
      .upd_err_o      (upd_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] mk(input logic [1:0] s, input logic [2:0] c,
                                        input logic [2:0] d);
      logic [FW-1:0] f;
      f = {d, c, s};
`ifdef DFT_CAPTURE_PARITY_EN
      mk = {^f, f};
`else
      mk = f;
`endif
   endfunction

   // LSB goes in first so it ends up at sr[0] after SW right shifts
   task automatic shift_word(input logic [SW-1:0] w, input bit upd_on_last);
      for (int i = 0; i < SW; i++) begin
         tdr_si       = w[i];
         tdr_shift_en = 1'b1;
         tdr_update   = upd_on_last && (i == SW - 1);
         tick();
      end
      tdr_shift_en = 1'b0;
      tdr_update   = 1'b0;
      tdr_si       = 1'b0;
   endtask

   // Update pulse, then one more edge for the registered select
   task automatic do_update();
      tdr_update = 1'b1;
      tick();
      tdr_update = 1'b0;
      tick();
   endtask

   task automatic rearm();
      capture_trig = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({tdr_so, ddr_clk_sel, capture_en, capture_busy, capture_done, upd_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0000000",
                  {tdr_so, ddr_clk_sel, capture_en, capture_busy, capture_done, upd_err});
      end
      rstn = 1'b1;
      tick();
      checks++;
      if (capture_busy !== 1'b0 || ddr_clk_sel !== 2'b00) begin
         errors++;
         $display("FAIL reset_release: busy=%b sel=%b want 0 00", capture_busy, ddr_clk_sel);
      end
   endtask

   task automatic test_load_capture();
      int n = 0;
      int en_cnt = 1;
      int done_cnt = 0;
      bit sel_bad = 0;
      scan_mode = 1'b1;
      shift_word(mk(2'b10, 3'd3, 3'd2), 0);
      do_update();
      checks++;
      if (ddr_clk_sel !== 2'b10) begin
         errors++;
         $display("FAIL load_sel: got %b want 10", ddr_clk_sel);
      end
      capture_trig = 1'b1;
      for (int k = 1; k <= 40 && n == 0; k++) begin
         tick();
         if (capture_en === 1'b1) n = k;
      end
      // 3 to trig_det, 1 to enter DELAY, dly+1 = 3 in DELAY
      checks++;
      if (n != 7) begin
         errors++;
         $display("FAIL capture_latency: got %0d edges want 7", n);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (capture_en === 1'b1) en_cnt++;
         if (capture_done === 1'b1) done_cnt++;
         if (ddr_clk_sel !== 2'b10) sel_bad = 1;
      end
      checks++;
      if (en_cnt != 3) begin
         errors++;
         $display("FAIL capture_en_len: got %0d want 3", en_cnt);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL capture_done_cnt: got %0d want 1", done_cnt);
      end
      checks++;
      if (sel_bad || capture_busy !== 1'b0) begin
         errors++;
         $display("FAIL window_end: sel_bad=%0d busy=%b want 0 0", sel_bad, capture_busy);
      end
      rearm();
   endtask

   task automatic test_zero_encodings();
      int kb = 0;
      int ke = 0;
      int en_cnt = 1;
      bit ended = 0;
      shift_word(mk(2'b01, 3'd0, 3'd0), 0);
      do_update();
      checks++;
      if (ddr_clk_sel !== 2'b01) begin
         errors++;
         $display("FAIL zero_sel: got %b want 01", ddr_clk_sel);
      end
      capture_trig = 1'b1;
      for (int k = 1; k <= 40 && ke == 0; k++) begin
         tick();
         if (capture_busy === 1'b1 && kb == 0) kb = k;
         if (capture_en === 1'b1) ke = k;
      end
      checks++;
      if (kb == 0 || ke - kb != 1) begin
         errors++;
         $display("FAIL zero_delay_len: busy@%0d en@%0d want gap 1", kb, ke);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (capture_en === 1'b1 && !ended) en_cnt++;
         else ended = 1;
      end
      checks++;
      if (en_cnt != 8) begin
         errors++;
         $display("FAIL zero_pulse_len: got %0d want 8", en_cnt);
      end
      rearm();
   endtask

   task automatic test_sel_zero();
      bit seen = 0;
      shift_word(mk(2'b00, 3'd3, 3'd2), 0);
      do_update();
      for (int t = 0; t < 2; t++) begin
         capture_trig = 1'b1;
         for (int k = 0; k < 15; k++) begin
            tick();
            if (capture_busy !== 1'b0 || capture_en !== 1'b0) seen = 1;
         end
         capture_trig = 1'b0;
         repeat (4) tick();
      end
      checks++;
      if (seen || ddr_clk_sel !== 2'b00) begin
         errors++;
         $display("FAIL sel00_ignored: activity=%0d sel=%b want 0 00", seen, ddr_clk_sel);
      end
   endtask

   task automatic test_abort();
      bit seen = 0;
      int en_cnt = 0;
      int done_cnt = 0;
      shift_word(mk(2'b10, 3'd2, 3'd5), 0);
      do_update();
      capture_trig = 1'b1;
      for (int k = 0; k < 20 && capture_busy !== 1'b1; k++) tick();
      checks++;
      if (capture_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_start: busy=%b want 1", capture_busy);
      end
      tick();
      scan_mode = 1'b0;
      tick();
      checks++;
      if (capture_busy !== 1'b0 || capture_en !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b en=%b want 0 0", capture_busy, capture_en);
      end
      for (int k = 0; k < 15; k++) begin
         tick();
         if (capture_en !== 1'b0 || capture_done !== 1'b0 || capture_busy !== 1'b0) seen = 1;
      end
      checks++;
      if (seen || ddr_clk_sel !== 2'b10) begin
         errors++;
         $display("FAIL abort_quiet: activity=%0d sel=%b want 0 10", seen, ddr_clk_sel);
      end
      scan_mode = 1'b1;
      rearm();
      capture_trig = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (capture_en === 1'b1) en_cnt++;
         if (capture_done === 1'b1) done_cnt++;
      end
      checks++;
      if (en_cnt != 2 || done_cnt != 1) begin
         errors++;
         $display("FAIL abort_retrigger: en=%0d done=%0d want 2 1", en_cnt, done_cnt);
      end
      rearm();
   endtask

   task automatic test_shift_priority();
      shift_word(mk(2'b10, 3'd3, 3'd2), 0);
      do_update();
      // Second word has sel=01 and the update is held during its last shift
      shift_word(mk(2'b01, 3'd1, 3'd0), 1);
      tick();
      tick();
      checks++;
      if (ddr_clk_sel !== 2'b10 || upd_err !== 1'b0) begin
         errors++;
         $display("FAIL shift_priority: sel=%b err=%b want 10 0", ddr_clk_sel, upd_err);
      end
      checks++;
      if (tdr_so !== 1'b1) begin
         errors++;
         $display("FAIL tdr_so: got %b want 1", tdr_so);
      end
   endtask

   task automatic test_upd_busy();
      int en_cnt = 0;
      int done_cnt = 0;
      bit sel_bad = 0;
      capture_trig = 1'b1;
      for (int k = 0; k < 40 && capture_en !== 1'b1; k++) tick();
      if (capture_en === 1'b1) en_cnt = 1;
      tdr_update = 1'b1;
      tick();
      tdr_update = 1'b0;
      if (capture_en === 1'b1) en_cnt++;
      tick();
      checks++;
      if (upd_err !== 1'b1 || ddr_clk_sel !== 2'b10) begin
         errors++;
         $display("FAIL upd_busy_flag: err=%b sel=%b want 1 10", upd_err, ddr_clk_sel);
      end
      if (capture_en === 1'b1) en_cnt++;
      if (capture_done === 1'b1) done_cnt++;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (capture_en === 1'b1) en_cnt++;
         if (capture_done === 1'b1) done_cnt++;
         if (ddr_clk_sel !== 2'b10) sel_bad = 1;
      end
      checks++;
      if (en_cnt != 3 || done_cnt != 1 || sel_bad || upd_err !== 1'b1) begin
         errors++;
         $display("FAIL upd_busy_window: en=%0d done=%0d sel_bad=%0d err=%b want 3 1 0 1",
                  en_cnt, done_cnt, sel_bad, upd_err);
      end
      rearm();
      do_update();
      checks++;
      if (ddr_clk_sel !== 2'b01) begin
         errors++;
         $display("FAIL upd_after_idle: sel=%b want 01", ddr_clk_sel);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bit seen = 0;
      shift_word(mk(2'b11, 3'd4, 3'd1), 0);
      do_update();
      capture_trig = 1'b1;
      for (int k = 0; k < 40 && capture_en !== 1'b1; k++) tick();
      tick();
      checks++;
      if (capture_en !== 1'b1 || ddr_clk_sel !== 2'b11 || upd_err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: en=%b sel=%b err=%b want 1 11 1", capture_en, ddr_clk_sel, upd_err);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({capture_en, capture_busy, capture_done, ddr_clk_sel, upd_err} !== 6'b0) begin
         errors++;
         $display("FAIL async_reset: en/busy/done/sel/err=%b want 000000",
                  {capture_en, capture_busy, capture_done, ddr_clk_sel, upd_err});
      end
      #3 rstn = 1'b1;
      tick();
      rearm();
      capture_trig = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (capture_busy !== 1'b0 || capture_en !== 1'b0 || ddr_clk_sel !== 2'b00) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL post_reset_idle: activity=%0d want 0", seen);
      end
      rearm();
   endtask

`ifdef DFT_CAPTURE_PARITY_EN
   task automatic test_parity();
      logic [SW-1:0] w;
      w = mk(2'b11, 3'd2, 3'd2);
      w[SW-1] = ~w[SW-1];
      shift_word(w, 0);
      do_update();
      checks++;
      if (ddr_clk_sel !== 2'b00 || upd_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_reject: sel=%b err=%b want 00 1", ddr_clk_sel, upd_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_capture();
      test_zero_encodings();
      test_sel_zero();
      test_abort();
      test_shift_priority();
      test_upd_busy();
      test_reset_mid_pulse();
`ifdef DFT_CAPTURE_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
